// File: rtl/pe_array_scan_pkg.sv
// Shared types for the PE array host controller: PE command codes, cell width, FSM states.
// The RUN state exists only when PE_ARRAY_SCAN_AUTORUN_EN is defined.
package pe_array_scan_pkg;

    localparam int unsigned PE_STATE_BITS = 1;
    localparam int unsigned PE_CMD_BITS   = 2;

    typedef enum logic [PE_CMD_BITS-1:0] {
        PE_NOP     = 2'd0,
        PE_WRITE   = 2'd1,
        PE_PROCESS = 2'd2
    } pe_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_READ_SEL  = 3'd2,
        S_READ_CAP  = 3'd3,
        S_READ_WAIT = 3'd4
`ifdef PE_ARRAY_SCAN_AUTORUN_EN
        ,
        S_RUN       = 3'd5
`endif
    } scan_state_e;

    // Raster index width for an n-entry dimension (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_array_scan_if.sv
// Host-side load and readout valid/ready ports of pe_array_scan.
interface pe_array_scan_if;
    import pe_array_scan_pkg::*;

    logic [PE_STATE_BITS-1:0] load_data;
    logic                     load_valid;
    logic                     load_ready;
    logic [PE_STATE_BITS-1:0] rd_data;
    logic                     rd_valid;
    logic                     rd_ready;
    logic                     rd_last;

    modport master (
        output load_data, load_valid, rd_ready,
        input  load_ready, rd_data, rd_valid, rd_last
    );

    modport slave (
        input  load_data, load_valid, rd_ready,
        output load_ready, rd_data, rd_valid, rd_last
    );
endinterface

// File: rtl/pe_scan_raster.sv
// Row-major raster position shared by load and readout, with one-hot decode and last-cell flag.
module pe_scan_raster
    import pe_array_scan_pkg::*;
#(
    parameter int unsigned ROWS = 16,
    parameter int unsigned COLS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    output logic [ROWS-1:0] row_oh,
    output logic [COLS-1:0] col_oh,
    output logic            last
);
    localparam int unsigned ROW_W = idx_w(ROWS);
    localparam int unsigned COL_W = idx_w(COLS);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             row_end;
    logic             col_end;

    assign row_end = (row == ROW_W'(ROWS - 1));
    assign col_end = (col == COL_W'(COLS - 1));
    assign last    = row_end && col_end;
    assign row_oh  = ROWS'(1) << row;
    assign col_oh  = COLS'(1) << col;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end
endmodule

// File: rtl/pe_array_scan.sv
// Host controller for the PE array: raster load via WRITE, generation stepping via PROCESS,
// raster readout via one-hot output selects. PE_ARRAY_SCAN_AUTORUN_EN adds run/RUN.
module pe_array_scan
    import pe_array_scan_pkg::*;
#(
    parameter int unsigned ROWS  = 16,
    parameter int unsigned COLS  = 16,
    parameter int unsigned GEN_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    pe_array_scan_if.slave           host,
    input  logic                     start_load,
    input  logic                     start_read,
    input  logic                     step,
`ifdef PE_ARRAY_SCAN_AUTORUN_EN
    input  logic                     run,
`endif
    input  logic                     any_active,
    input  logic [PE_STATE_BITS-1:0] array_state,
    output pe_cmd_e                  cmd,
    output logic [ROWS-1:0]          rsel_i,
    output logic [COLS-1:0]          csel_i,
    output logic [ROWS-1:0]          rsel_o,
    output logic [COLS-1:0]          csel_o,
    output logic [PE_STATE_BITS-1:0] state_in,
    output logic                     busy,
    output logic                     stable,
    output logic [GEN_W-1:0]         gen_count
);
    scan_state_e     state;
    logic [ROWS-1:0] row_oh;
    logic [COLS-1:0] col_oh;
    logic            last;
    logic            beat;
    logic            proc;
    logic            rd_hs;
    logic            read_sel;
    logic            raster_clear;
    logic            raster_adv;
    logic            idle_step;

    assign beat         = (state == S_LOAD) && host.load_valid;
    assign rd_hs        = (state == S_READ_WAIT) && host.rd_ready;
    assign read_sel     = (state == S_READ_SEL) || (state == S_READ_CAP);
    assign raster_clear = (state == S_IDLE) && (start_load || start_read);
    assign raster_adv   = beat || rd_hs;
    assign idle_step    = (state == S_IDLE) && step && !start_load && !start_read;
`ifdef PE_ARRAY_SCAN_AUTORUN_EN
    assign proc = idle_step || (state == S_RUN);
`else
    assign proc = idle_step;
`endif

    assign host.load_ready = (state == S_LOAD);
    assign busy            = (state != S_IDLE);
    assign rsel_i          = beat ? row_oh : '0;
    assign csel_i          = beat ? col_oh : '0;
    assign state_in        = beat ? host.load_data : '0;
    assign rsel_o          = read_sel ? row_oh : '0;
    assign csel_o          = read_sel ? col_oh : '0;

    // WRITE and PROCESS are issued in the same cycle as the beat / step request.
    always_comb begin
        cmd = PE_NOP;
        if (beat) begin
            cmd = PE_WRITE;
        end else if (proc) begin
            cmd = PE_PROCESS;
        end
    end

    pe_scan_raster #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (raster_clear),
        .advance (raster_adv),
        .row_oh  (row_oh),
        .col_oh  (col_oh),
        .last    (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            host.rd_data  <= '0;
            host.rd_valid <= 1'b0;
            host.rd_last  <= 1'b0;
            stable        <= 1'b0;
            gen_count     <= '0;
        end else begin
            if (proc) begin
                stable    <= !any_active;
                gen_count <= gen_count + GEN_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start_load) begin
                        state <= S_LOAD;
                    end else if (start_read) begin
                        state <= S_READ_SEL;
`ifdef PE_ARRAY_SCAN_AUTORUN_EN
                    end else if (!step && run) begin
                        state <= S_RUN;
`endif
                    end
                end
                S_LOAD: begin
                    if (beat && last) begin
                        state     <= S_IDLE;
                        gen_count <= '0;
                        stable    <= 1'b0;
                    end
                end
                S_READ_SEL: state <= S_READ_CAP;
                S_READ_CAP: begin
                    host.rd_data  <= array_state;
                    host.rd_valid <= 1'b1;
                    host.rd_last  <= last;
                    state         <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (host.rd_ready) begin
                        host.rd_valid <= 1'b0;
                        host.rd_last  <= 1'b0;
                        state         <= last ? S_IDLE : S_READ_SEL;
                    end
                end
`ifdef PE_ARRAY_SCAN_AUTORUN_EN
                S_RUN: begin
                    if (!any_active || !run) begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
